trng_sample_ctrl: RTL

TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

---
 rtl/trng_pkg.sv | 26 ++
 rtl/trng_sync.sv | 59 +++++
 rtl/trng_sample_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trng_pkg
// Description : Shared definitions for the TRNG sampling controller: FSM state
//               encoding, parameter defaults and the repetition counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    localparam int unsigned WORD_W_DEFAULT     = 32;
    localparam int unsigned WARMUP_CYC_DEFAULT = 256;
    localparam int unsigned REP_LIMIT_DEFAULT  = 31;

    // Wide enough for the largest legal repetition limit (255).
    localparam int unsigned REP_CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FAULT   = 3'd4
    } trng_state_e;

endpackage : trng_pkg
`default_nettype wire

// File: rtl/trng_sync.sv
`default_nettype none
// ============================================================================
// Module      : trng_sync
// Description : Two-flop synchronizer for an asynchronous oscillator input,
//               with an optional rising-edge detector on the synchronized
//               level. The oscillator is only ever sampled as data.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               async_i  - asynchronous input
//               level_o  - synchronized level
//               rise_o   - one-cycle pulse on a synchronized 0->1 transition
//                          (constant 0 when EDGE_EN = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module trng_sync #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign level_o = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise_o = sync_q & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule : trng_sync
`default_nettype wire

// File: rtl/trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trng_sample_ctrl
// Description : Ring-oscillator TRNG sampling controller. The fast oscillator
//               is sampled on rising edges of the slow oscillator, raw bits
//               are von Neumann debiased into WORD_W-bit words delivered over
//               a valid/ready handshake, and a repetition-count health test
//               latches a sticky fault.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               en         - enable; low returns to IDLE
//               osc_a      - fast oscillator (sampled data)
//               osc_b      - slow oscillator (sampling strobe)
//               rnd_rdy    - downstream ready
//               rnd_data   - debiased random word
//               rnd_valid  - rnd_data valid
//               fault      - sticky health-test failure
// Revision    : 1.0 - initial release
// ============================================================================
module trng_sample_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEFAULT,
    parameter int unsigned WARMUP_CYC = WARMUP_CYC_DEFAULT,
    parameter int unsigned REP_LIMIT  = REP_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              osc_a,
    input  logic              osc_b,
    input  logic              rnd_rdy,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    output logic              fault
);

    localparam int unsigned c_CNT_W  = $clog2(WORD_W + 1);
    localparam int unsigned c_WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

    localparam logic [c_CNT_W-1:0]   c_BIT_LAST  = c_CNT_W'(WORD_W - 1);
    localparam logic [c_WARM_W-1:0]  c_WARM_LAST = c_WARM_W'(WARMUP_CYC - 1);
    localparam logic [REP_CNT_W-1:0] c_REP_TRIP  = REP_CNT_W'(REP_LIMIT);

    // ------------------------------------------------------------------
    // Oscillator synchronizers
    // ------------------------------------------------------------------
    logic w_raw;
    logic w_sample;
    logic w_osc_b_level_unused;
    logic w_osc_a_rise_unused;

    trng_sync #(
        .EDGE_EN (1'b0)
    ) u_sync_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (osc_a),
        .level_o (w_raw),
        .rise_o  (w_osc_a_rise_unused)
    );

    trng_sync #(
        .EDGE_EN (1'b1)
    ) u_sync_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (osc_b),
        .level_o (w_osc_b_level_unused),
        .rise_o  (w_sample)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    trng_state_e            state_q,    state_d;
    logic [c_WARM_W-1:0]    warm_q,     warm_d;
    logic [c_CNT_W-1:0]     bitcnt_q,   bitcnt_d;
    logic [WORD_W-1:0]      word_q,     word_d;
    logic                   valid_q,    valid_d;
    logic                   fault_q,    fault_d;
    logic                   pair_vld_q, pair_vld_d;
    logic                   pair_bit_q, pair_bit_d;
    logic [REP_CNT_W-1:0]   rep_cnt_q,  rep_cnt_d;
    logic                   rep_bit_q,  rep_bit_d;

    // Run length including the current sample. A zero count means no sample
    // has been seen since the test was cleared, so the first one starts a run.
    logic [REP_CNT_W-1:0]   w_rep_next;
    logic                   w_rep_trip;

    assign w_rep_next = ((rep_cnt_q != '0) && (w_raw == rep_bit_q))
                        ? (rep_cnt_q + 1'b1) : REP_CNT_W'(1);
    assign w_rep_trip = w_sample && (w_rep_next == c_REP_TRIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            warm_q     <= '0;
            bitcnt_q   <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
            rep_cnt_q  <= '0;
            rep_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            bitcnt_q   <= bitcnt_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            pair_vld_q <= pair_vld_d;
            pair_bit_q <= pair_bit_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_bit_q  <= rep_bit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        bitcnt_d   = bitcnt_q;
        word_d     = word_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        pair_vld_d = pair_vld_q;
        pair_bit_d = pair_bit_q;
        rep_cnt_d  = rep_cnt_q;
        rep_bit_d  = rep_bit_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                end
            end

            // Samples are ignored while the oscillators settle.
            ST_WARMUP: begin
                if (warm_q == c_WARM_LAST) begin
                    state_d = ST_COLLECT;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end

            ST_COLLECT: begin
                if (w_sample) begin
                    rep_cnt_d = w_rep_next;
                    rep_bit_d = w_raw;
                    if (w_rep_trip) begin
                        // Health failure outranks a word completing now.
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        pair_vld_d = 1'b0;
                    end else if (!pair_vld_q) begin
                        pair_vld_d = 1'b1;
                        pair_bit_d = w_raw;
                    end else begin
                        // Second bit of a pair: 10 -> 1, 01 -> 0, i.e. the
                        // first bit is emitted whenever the two differ.
                        pair_vld_d = 1'b0;
                        if (w_raw != pair_bit_q) begin
                            word_d   = {word_q[WORD_W-2:0], pair_bit_q};
                            bitcnt_d = bitcnt_q + 1'b1;
                            if (bitcnt_q == c_BIT_LAST) begin
                                state_d = ST_PRESENT;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
            end

            // Word on offer: raw bits feed only the health test.
            ST_PRESENT: begin
                pair_vld_d = 1'b0;
                if (w_sample) begin
                    rep_cnt_d = w_rep_next;
                    rep_bit_d = w_raw;
                end
                if (w_rep_trip) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (valid_q && rnd_rdy) begin
                    state_d  = ST_COLLECT;
                    valid_d  = 1'b0;
                    bitcnt_d = '0;
                end
            end

            ST_FAULT: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable overrides everything; the word register is kept but any
        // pending word is no longer offered.
        if (!en) begin
            state_d    = ST_IDLE;
            warm_d     = '0;
            valid_d    = 1'b0;
            fault_d    = 1'b0;
            bitcnt_d   = '0;
            pair_vld_d = 1'b0;
            pair_bit_d = 1'b0;
            rep_cnt_d  = '0;
            rep_bit_d  = 1'b0;
        end
    end

    assign rnd_data  = word_q;
    assign rnd_valid = valid_q;
    assign fault     = fault_q;

endmodule : trng_sample_ctrl
`default_nettype wire
